delivery_game_velocity: RTL and testbench



---
 rtl/delivery_game_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 40 ++++
 rtl/delivery_game_velocity.sv | 159 +++++++++++++++
 tb/tb_delivery_game_velocity.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_game_pkg.sv
// -----------------------------------------------------------------------------
// delivery_game_pkg
//   Shared definitions for the delivery game blocks.
//   - vel_state_t : state codes of the velocity acquisition FSM (also shown on
//                   the debug display through the estado port)
//   - VEL_0..VEL_3: 2-bit velocity levels, 0 = slowest, 3 = fastest
//   - DEF_*       : default timing constants for the 50 MHz system clock, so
//                   the control unit and the velocity stage share one base
// -----------------------------------------------------------------------------
package delivery_game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TRIGGER   = 4'd1,
        ST_WAIT_ECHO = 4'd2,
        ST_MEASURE   = 4'd3,
        ST_DONE      = 4'd4
    } vel_state_t;

    localparam logic [1:0] VEL_0 = 2'd0;
    localparam logic [1:0] VEL_1 = 2'd1;
    localparam logic [1:0] VEL_2 = 2'd2;
    localparam logic [1:0] VEL_3 = 2'd3;

    localparam int unsigned CLK_HZ             = 50_000_000;
    localparam int unsigned DEF_TRIG_CYCLES    = 500;        // 10 us trigger
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_250_000;  // 25 ms
    localparam int unsigned DEF_T1             = 29_000;
    localparam int unsigned DEF_T2             = 58_000;
    localparam int unsigned DEF_T3             = 87_000;
    localparam int unsigned DEF_COUNT_W        = 21;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for asynchronous inputs (sensor echo, buttons).
//   Each bit is synchronised independently; output latency is 2 clocks.
// Ports:
//   clock  in          system clock
//   reset  in          synchronous, active-high reset (clears both stages)
//   d      in  WIDTH   asynchronous inputs
//   q      out WIDTH   synchronised outputs
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/delivery_game_velocity.sv
// -----------------------------------------------------------------------------
// delivery_game_velocity
//   Velocity acquisition stage feeding the delivery game control unit.
//   A get_velocity request fires an ultrasonic ranging cycle: the trigger is
//   held high for TRIG_CYCLES clocks, the echo pulse width is counted and then
//   quantised into a 2-bit level. Results are held until the next measurement.
// Ports:
//   clock           in      system clock
//   reset           in      synchronous, active-high reset
//   get_velocity    in      start request (level or pulse), honoured in IDLE
//   echo            in      asynchronous sensor echo
//   trigger         out     sensor trigger (decoded from state)
//   velocity        out 2   quantised level, 0 = slowest, 3 = fastest
//   velocity_ready  out     one-cycle pulse, measurement complete
//   timeout         out     last measurement timed out (held with velocity)
//   busy            out     high in every state except IDLE
//   estado          out 4   current state code for the debug display
// -----------------------------------------------------------------------------
module delivery_game_velocity
    import delivery_game_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned T1             = DEF_T1,
    parameter int unsigned T2             = DEF_T2,
    parameter int unsigned T3             = DEF_T3,
    parameter int unsigned COUNT_W        = DEF_COUNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       get_velocity,
    input  logic       echo,
    output logic       trigger,
    output logic [1:0] velocity,
    output logic       velocity_ready,
    output logic       timeout,
    output logic       busy,
    output logic [3:0] estado
);

    localparam logic [COUNT_W-1:0] TRIG_LAST    = COUNT_W'(TRIG_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] T1_C         = COUNT_W'(T1);
    localparam logic [COUNT_W-1:0] T2_C         = COUNT_W'(T2);
    localparam logic [COUNT_W-1:0] T3_C         = COUNT_W'(T3);
    localparam logic [COUNT_W-1:0] ONE_C        = COUNT_W'(1);

    vel_state_t         state_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [1:0]         velocity_reg;
    logic               timeout_reg;
    logic               echo_d_reg;
    logic               echo_s;
    logic               echo_rise;
    logic [1:0]         level_next;

    // Echo path: every decision uses the synchronised echo_s, so the raw
    // input reaches the FSM two clocks after it changes.
    sync_2ff #(
        .WIDTH (1)
    ) u_echo_sync (
        .clock (clock),
        .reset (reset),
        .d     (echo),
        .q     (echo_s)
    );

    // Only a fresh rising edge starts a measurement; an echo that is already
    // high when the wait begins is ignored.
    assign echo_rise = echo_s & ~echo_d_reg;

    // Classifier on the current count: shorter echo means a closer hand,
    // which maps to a faster level.
    always_comb begin
        level_next = VEL_0;
        if (count_reg < T1_C) begin
            level_next = VEL_3;
        end else if (count_reg < T2_C) begin
            level_next = VEL_2;
        end else if (count_reg < T3_C) begin
            level_next = VEL_1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            velocity_reg <= VEL_0;
            timeout_reg  <= 1'b0;
            echo_d_reg   <= 1'b0;
        end else begin
            echo_d_reg <= echo_s;
            case (state_reg)
                ST_IDLE: begin
                    if (get_velocity) begin
                        state_reg <= ST_TRIGGER;
                        count_reg <= '0;
                    end
                end

                ST_TRIGGER: begin
                    if (count_reg == TRIG_LAST) begin
                        state_reg <= ST_WAIT_ECHO;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + ONE_C;
                    end
                end

                ST_WAIT_ECHO: begin
                    if (echo_rise) begin
                        // The rise cycle itself is part of the echo width.
                        state_reg <= ST_MEASURE;
                        count_reg <= ONE_C;
                    end else if (count_reg == TIMEOUT_LAST) begin
                        state_reg    <= ST_DONE;
                        velocity_reg <= VEL_0;
                        timeout_reg  <= 1'b1;
                    end else begin
                        count_reg <= count_reg + ONE_C;
                    end
                end

                ST_MEASURE: begin
                    if (!echo_s) begin
                        state_reg    <= ST_DONE;
                        velocity_reg <= level_next;
                        timeout_reg  <= 1'b0;
                    end else if (count_reg == TIMEOUT_LAST) begin
                        // Saturate instead of wrapping on a stuck echo.
                        state_reg    <= ST_DONE;
                        velocity_reg <= VEL_0;
                        timeout_reg  <= 1'b1;
                    end else begin
                        count_reg <= count_reg + ONE_C;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register only.
    assign trigger        = (state_reg == ST_TRIGGER);
    assign velocity_ready = (state_reg == ST_DONE);
    assign busy           = (state_reg != ST_IDLE);
    assign estado         = state_reg;
    assign velocity       = velocity_reg;
    assign timeout        = timeout_reg;

endmodule

// File: tb/tb_delivery_game_velocity.sv
// -----------------------------------------------------------------------------
// tb_delivery_game_velocity
//   Scoreboard bench: each issued measurement pushes its expected
//   {velocity, timeout}; a monitor pops and compares on every ready pulse.
// -----------------------------------------------------------------------------
module tb_delivery_game_velocity;

    logic       clock;
    logic       reset;
    logic       get_velocity;
    logic       echo;
    logic       trigger;
    logic [1:0] velocity;
    logic       velocity_ready;
    logic       timeout;
    logic       busy;
    logic [3:0] estado;

    typedef struct {
        logic [1:0] vel;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run   = 0;
    int   fail_count  = 0;
    int   ready_count = 0;
    int   cyc         = 0;

    delivery_game_velocity #(
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (100),
        .T1             (10),
        .T2             (20),
        .T3             (30),
        .COUNT_W        (21)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .get_velocity   (get_velocity),
        .echo           (echo),
        .trigger        (trigger),
        .velocity       (velocity),
        .velocity_ready (velocity_ready),
        .timeout        (timeout),
        .busy           (busy),
        .estado         (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            fail_count++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end else begin
            $display("[TB] ok %s = %0d (cycle %0d)", name, actual, cyc);
        end
    endtask

    // Monitor: one comparison set per ready pulse.
    always @(negedge clock) begin
        if (!reset && velocity_ready) begin
            exp_t e;
            ready_count++;
            if (exp_q.size() == 0) begin
                tests_run++;
                fail_count++;
                $display("FAIL unexpected_ready: got velocity=%0d timeout=%0d, expected no pulse", velocity, timeout);
            end else begin
                e = exp_q.pop_front();
                check("ready_velocity", int'(velocity), int'(e.vel));
                check("ready_timeout", int'(timeout), int'(e.to));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] vel, input logic to);
        exp_t e;
        e.vel = vel;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, input string name);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            if (estado == code) begin
                found = 1;
                break;
            end
            tick(1);
        end
        check(name, found, 1);
    endtask

    task automatic wait_ready(input int budget, input string name);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (velocity_ready) begin
                found = 1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    // Issue a request from IDLE; returns one clock later (state TRIGGER).
    task automatic request();
        wait_state(4'd0, 50, "idle_before_request");
        get_velocity = 1'b1;
        tick(1);
        get_velocity = 1'b0;
    endtask

    task automatic run_meas(input int width, input string name);
        request();
        wait_state(4'd2, 50, "enter_wait_echo");
        echo = 1'b1;
        tick(width);
        echo = 1'b0;
        wait_ready(200, name);
    endtask

    initial begin
        int t0;
        reset        = 1'b1;
        get_velocity = 1'b0;
        echo         = 1'b0;
        tick(3);
        check("rst_estado", int'(estado), 0);
        check("rst_trigger", int'(trigger), 0);
        check("rst_velocity", int'(velocity), 0);
        check("rst_ready", int'(velocity_ready), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick(2);

        // 1: width 15 -> level 2, trigger high exactly 4 clocks
        push_exp(2'd2, 1'b0);
        request();
        for (int i = 0; i < 6; i++) begin
            check("t1_trigger", int'(trigger), (i < 4) ? 1 : 0);
            tick(1);
        end
        echo = 1'b1;
        tick(15);
        echo = 1'b0;
        wait_ready(200, "t1_ready_seen");
        tick(1);
        check("t1_busy_after", int'(busy), 0);
        check("t1_estado_after", int'(estado), 0);
        tick(2);
        check("t1_ready_count", ready_count, 1);

        // 2: widths 5, 25, 45 -> levels 3, 1, 0
        push_exp(2'd3, 1'b0);
        run_meas(5, "t2a_ready_seen");
        push_exp(2'd1, 1'b0);
        run_meas(25, "t2b_ready_seen");
        push_exp(2'd0, 1'b0);
        run_meas(45, "t2c_ready_seen");
        tick(2);
        check("t2_ready_count", ready_count, 4);

        // 3: no echo -> timeout 100 clocks after entering WAIT_ECHO
        push_exp(2'd0, 1'b1);
        request();
        wait_state(4'd2, 50, "t3_enter_wait");
        t0 = cyc;
        wait_ready(300, "t3_ready_seen");
        check("t3_latency", cyc - t0, 100);
        tick(2);
        check("t3_ready_count", ready_count, 5);

        // 4: echo stuck high -> saturate, then a normal run clears timeout
        push_exp(2'd0, 1'b1);
        request();
        wait_state(4'd2, 50, "t4_enter_wait");
        echo = 1'b1;
        t0 = cyc;
        wait_ready(300, "t4_ready_seen");
        check("t4_latency", cyc - t0, 102);
        tick(100);
        echo = 1'b0;
        tick(10);
        check("t4_ready_count", ready_count, 6);
        check("t4_estado_idle", int'(estado), 0);
        push_exp(2'd3, 1'b0);
        run_meas(5, "t4b_ready_seen");
        tick(2);
        check("t4_ready_count2", ready_count, 7);
        check("t4_timeout_cleared", int'(timeout), 0);

        // 5: extra requests during TRIGGER and MEASURE are ignored
        push_exp(2'd1, 1'b0);
        request();
        get_velocity = 1'b1;
        tick(1);
        get_velocity = 1'b0;
        wait_state(4'd2, 50, "t5_enter_wait");
        echo = 1'b1;
        tick(5);
        get_velocity = 1'b1;
        tick(1);
        get_velocity = 1'b0;
        tick(19);
        echo = 1'b0;
        wait_ready(200, "t5_ready_seen");
        tick(20);
        check("t5_ready_count", ready_count, 8);
        check("t5_estado_idle", int'(estado), 0);

        // 6: reset mid-MEASURE aborts with no ready pulse
        request();
        wait_state(4'd2, 50, "t6_enter_wait");
        echo = 1'b1;
        tick(10);
        check("t6_in_measure", int'(estado), 3);
        reset = 1'b1;
        tick(1);
        check("t6_estado", int'(estado), 0);
        check("t6_trigger", int'(trigger), 0);
        check("t6_velocity", int'(velocity), 0);
        check("t6_busy", int'(busy), 0);
        reset = 1'b0;
        echo  = 1'b0;
        tick(10);
        check("t6_no_ready", ready_count, 8);
        push_exp(2'd1, 1'b0);
        run_meas(25, "t6b_ready_seen");
        tick(2);
        check("t6_ready_count", ready_count, 9);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
